// File: rtl/gpu_pixel_queue.sv
// rtl/gpu_pixel_queue.sv - elastic pixel FIFO with paced memory-controller write strobes and end-of-frame flush
module gpu_pixel_queue #(
  parameter int DEPTH        = 8,
  parameter int WRITE_GAP    = 1,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int CHANNEL_BITS = 8,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  input  logic [CHANNEL_BITS-1:0]       r_i,
  input  logic [CHANNEL_BITS-1:0]       g_i,
  input  logic [CHANNEL_BITS-1:0]       b_i,
  input  logic [WIDTH_BITS-1:0]         x_i,
  input  logic [HEIGHT_BITS-1:0]        y_i,
  input  logic                          frame_done_i,
  output logic                          data_ready_o,
  output logic [CHANNEL_BITS-1:0]       rdata,
  output logic [CHANNEL_BITS-1:0]       gdata,
  output logic [CHANNEL_BITS-1:0]       bdata,
  output logic [WIDTH_BITS-1:0]         adddatax,
  output logic [HEIGHT_BITS-1:0]        adddatay,
  output logic                          flush,
  output logic                          busy,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [15:0]                   drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;
  localparam int XW = WIDTH_BITS + 1;
  localparam int YW = HEIGHT_BITS + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_C   = GW'(WRITE_GAP);
  localparam logic [XW-1:0] H_LIM   = XW'(H_RES);
  localparam logic [YW-1:0] V_LIM   = YW'(V_RES);

  typedef struct packed {
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
  } pix_t;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            dr_q, dr_d;
  pix_t            out_q, out_d;
  logic [15:0]     drop_q, drop_d;
  pix_t            mem_q [DEPTH];

  pix_t            in_pix;
  pix_t            head_pix;
  logic            in_range;
  logic            push;
  logic            store;
  logic            drop;
  logic            pop;
  logic            drain_done;

  assign in_pix   = '{r: r_i, g: g_i, b: b_i, x: x_i, y: y_i};
  assign head_pix = mem_q[rd_ptr_q];

  // Out-of-range pixels are still handshaked so the rasterizer never stalls on them.
  assign in_range = ({1'b0, x_i} < H_LIM) && ({1'b0, y_i} < V_LIM);
  assign push     = pix_valid_i && pix_ready_o;
  assign store    = push && in_range;
  assign drop     = push && !in_range;

  // A pop only looks at registered occupancy, so a pixel pushed this cycle leaves next cycle at the earliest.
  assign pop = (count_q != '0) && (gap_q == '0);

  // Drain is complete only once the last strobe and its trailing gap are both over.
  assign drain_done = (count_q == '0) && !dr_q && (gap_q == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state plus the ready/flush outputs it owns.
  always_comb begin
    state_d     = state_q;
    pix_ready_o = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        pix_ready_o = !rst && (count_q < DEPTH_C);
        if (frame_done_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        state_d = ST_ACCEPT;
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // Next-state for pointers, occupancy, pacing counter, output registers and drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    gap_d    = gap_q;
    dr_d     = pop;
    out_d    = out_q;
    drop_d   = drop_q;

    if (store) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      out_d    = head_pix;
      gap_d    = GAP_C;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end

    case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Control and output registers; everything visible outside clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      dr_q     <= 1'b0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      dr_q     <= dr_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= in_pix;
    end
  end

  assign data_ready_o = dr_q;
  assign rdata        = out_q.r;
  assign gdata        = out_q.g;
  assign bdata        = out_q.b;
  assign adddatax     = out_q.x;
  assign adddatay     = out_q.y;
  assign count_o      = count_q;
  assign drop_cnt_o   = drop_q;
  assign busy         = (state_q != ST_ACCEPT) || (count_q != '0) || dr_q;

endmodule
